// File: rtl/aroc_ss_pkg.sv
// Shared types and default build constants for the AROC serial-stream ID scanner.
package aroc_ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CMP
    } scan_state_e;

    localparam int DEF_NUM_BITS  = 4;
    localparam int DEF_FRAME_GAP = 16;
    localparam int DEF_LOAD_CYC  = 2;
    localparam int DEF_MATCH_CNT = 2;

endpackage

// File: rtl/aroc_ss_frame_filter.sv
// Debounces captured ID frames: publishes ROC_ID only after MATCH_CNT identical frames in a row.
module aroc_ss_frame_filter
    import aroc_ss_pkg::*;
#(
    parameter int NUM_BITS  = DEF_NUM_BITS,
    parameter int MATCH_CNT = DEF_MATCH_CNT
) (
    input  logic                AROC_SS_CLK,
    input  logic                PGD_AROC,
    input  logic [NUM_BITS-1:0] frame,
    input  logic                frame_strobe,
    output logic [NUM_BITS-1:0] ROC_ID,
    output logic                ROC_ID_VLD,
    output logic                ROC_ID_CHG
);

    localparam int MATCH_W = $clog2(MATCH_CNT + 1);

    logic [NUM_BITS-1:0] last_frame;
    logic [MATCH_W-1:0]  match_cnt;
    logic [MATCH_W-1:0]  match_nxt;
    logic                publish;

    function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v);
        return (v >= MATCH_W'(MATCH_CNT)) ? v : v + MATCH_W'(1);
    endfunction

    // A differing frame restarts the run at one, so a single glitch frame never publishes.
    always_comb begin
        match_nxt = (frame == last_frame) ? sat_inc(match_cnt) : MATCH_W'(1);
        publish   = frame_strobe && (match_nxt == MATCH_W'(MATCH_CNT)) &&
                    ((frame != ROC_ID) || !ROC_ID_VLD);
    end

    always_ff @(posedge AROC_SS_CLK) begin
        if (!PGD_AROC) begin
            last_frame <= '0;
            match_cnt  <= '0;
            ROC_ID     <= '0;
            ROC_ID_VLD <= 1'b0;
            ROC_ID_CHG <= 1'b0;
        end else begin
            ROC_ID_CHG <= publish;
            if (frame_strobe) begin
                last_frame <= frame;
                match_cnt  <= match_nxt;
            end
            if (publish) begin
                ROC_ID     <= frame;
                ROC_ID_VLD <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aroc_ss_scan_ctrl.sv
// Master sequencer for the AROC ID shift chain: load strobe, MSB-first shift-in, frame qualification.
module aroc_ss_scan_ctrl
    import aroc_ss_pkg::*;
#(
    parameter int NUM_BITS  = DEF_NUM_BITS,
    parameter int FRAME_GAP = DEF_FRAME_GAP,
    parameter int LOAD_CYC  = DEF_LOAD_CYC,
    parameter int MATCH_CNT = DEF_MATCH_CNT
) (
    input  logic                AROC_SS_CLK,
    input  logic                PGD_AROC,
    input  logic                SCAN_EN,
    input  logic                SCAN_NOW,
    input  logic                AROC_SS_DATI,
    output logic                AROC_SS_LD_N,
    output logic [NUM_BITS-1:0] ROC_ID,
    output logic                ROC_ID_VLD,
    output logic                ROC_ID_CHG,
    output logic                FRAME_DONE
);

    localparam int GAP_W  = $clog2(FRAME_GAP + 1);
    localparam int LOAD_W = $clog2(LOAD_CYC + 1);
    localparam int BIT_W  = $clog2(NUM_BITS + 1);

    scan_state_e         state;
    scan_state_e         state_nxt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [LOAD_W-1:0]   load_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [NUM_BITS-1:0] frame;
    logic                ld_n;
    logic                frame_done;

    // LD_N still low in IDLE only happens straight out of reset: the chain is already
    // parallel-loading, so the first frame starts without waiting out a gap.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (SCAN_EN && ((gap_cnt <= GAP_W'(1)) || SCAN_NOW || !ld_n))
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_cnt == LOAD_W'(LOAD_CYC - 1))
                    state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_W'(NUM_BITS - 1)) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_CMP;
                end
            end
            ST_CMP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge AROC_SS_CLK) begin
        if (!PGD_AROC) begin
            state    <= ST_IDLE;
            gap_cnt  <= GAP_W'(FRAME_GAP);
            load_cnt <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            ld_n     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ld_n     <= (state_nxt != ST_LOAD);
            load_cnt <= (state == ST_LOAD) ? load_cnt + LOAD_W'(1) : '0;
            bit_cnt  <= (state == ST_SHIFT) ? bit_cnt + BIT_W'(1) : '0;
            if (state == ST_SHIFT)
                frame <= {frame[NUM_BITS-2:0], AROC_SS_DATI};
            if (state == ST_CMP)
                gap_cnt <= GAP_W'(FRAME_GAP);
            else if ((state == ST_IDLE) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign AROC_SS_LD_N = ld_n;
    assign FRAME_DONE   = frame_done;

    aroc_ss_frame_filter #(
        .NUM_BITS  (NUM_BITS),
        .MATCH_CNT (MATCH_CNT)
    ) u_filter (
        .AROC_SS_CLK  (AROC_SS_CLK),
        .PGD_AROC     (PGD_AROC),
        .frame        (frame),
        .frame_strobe (state == ST_CMP),
        .ROC_ID       (ROC_ID),
        .ROC_ID_VLD   (ROC_ID_VLD),
        .ROC_ID_CHG   (ROC_ID_CHG)
    );

endmodule

// File: tb/tb_aroc_ss_scan_ctrl.sv
// Directed bench: PISO chain models feed a default build and an 8-bit MATCH_CNT=1 build.
module tb_aroc_ss_scan_ctrl;

    logic       clk;
    logic       pgd, scan_en, scan_now, dati, ld_n, vld, chg, fd;
    logic [3:0] roc_id, chain_id, sr;

    logic       pgd8, scan_en8, scan_now8, dati8, ld_n8, vld8, chg8, fd8;
    logic [7:0] roc_id8, chain_id8, sr8;

    int n_cmp = 0;
    int n_err = 0;
    int chg_cnt, fd_cnt, ld_cnt, chg8_cnt, fd8_cnt;

    typedef struct {
        logic [3:0] id;
        int         n;
        int         roc;
        int         vld;
        int         chg;
        int         fd;
        int         ld;
    } vec_t;
    vec_t tbl [8];

    aroc_ss_scan_ctrl u_dut (
        .AROC_SS_CLK  (clk),
        .PGD_AROC     (pgd),
        .SCAN_EN      (scan_en),
        .SCAN_NOW     (scan_now),
        .AROC_SS_DATI (dati),
        .AROC_SS_LD_N (ld_n),
        .ROC_ID       (roc_id),
        .ROC_ID_VLD   (vld),
        .ROC_ID_CHG   (chg),
        .FRAME_DONE   (fd)
    );

    aroc_ss_scan_ctrl #(.NUM_BITS(8), .MATCH_CNT(1)) u_dut8 (
        .AROC_SS_CLK  (clk),
        .PGD_AROC     (pgd8),
        .SCAN_EN      (scan_en8),
        .SCAN_NOW     (scan_now8),
        .AROC_SS_DATI (dati8),
        .AROC_SS_LD_N (ld_n8),
        .ROC_ID       (roc_id8),
        .ROC_ID_VLD   (vld8),
        .ROC_ID_CHG   (chg8),
        .FRAME_DONE   (fd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parallel-in/serial-out chains: load while LD_N is low, otherwise shift toward the MSB output.
    initial sr = '0;
    initial sr8 = '0;
    always @(posedge clk) begin
        if (!ld_n) sr <= chain_id;
        else       sr <= {sr[2:0], 1'b0};
        if (!ld_n8) sr8 <= chain_id8;
        else        sr8 <= {sr8[6:0], 1'b0};
    end
    assign dati  = sr[3];
    assign dati8 = sr8[7];

    task automatic step();
        @(posedge clk);
        #1;
        if (chg)   chg_cnt++;
        if (fd)    fd_cnt++;
        if (!ld_n) ld_cnt++;
        if (chg8)  chg8_cnt++;
        if (fd8)   fd8_cnt++;
    endtask

    task automatic clear_counts();
        chg_cnt = 0; fd_cnt = 0; ld_cnt = 0; chg8_cnt = 0; fd8_cnt = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_roc"},  int'(roc_id), 0);
        check({tag, "_vld"},  int'(vld), 0);
        check({tag, "_chg"},  int'(chg), 0);
        check({tag, "_fd"},   int'(fd), 0);
        check({tag, "_ld_n"}, int'(ld_n), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        // Edges counted from reset release; period 23, one frame CMP every 23 edges from edge 30.
        tbl[0] = '{4'h9, 30, 0, 0, 0, 2, 4};
        tbl[1] = '{4'h9,  1, 9, 1, 1, 0, 0};
        tbl[2] = '{4'h9, 23, 9, 1, 0, 1, 2};
        tbl[3] = '{4'h6, 23, 9, 1, 0, 1, 2};
        tbl[4] = '{4'h9, 23, 9, 1, 0, 1, 2};
        tbl[5] = '{4'h6, 23, 9, 1, 0, 1, 2};
        tbl[6] = '{4'h6, 23, 6, 1, 1, 1, 2};
        tbl[7] = '{4'h6, 23, 6, 1, 0, 1, 2};

        pgd = 1'b0; scan_en = 1'b1; scan_now = 1'b0; chain_id = 4'h9;
        pgd8 = 1'b0; scan_en8 = 1'b1; scan_now8 = 1'b0; chain_id8 = 8'hA5;
        clear_counts();
        repeat (3) step();
        check_reset("reset");

        pgd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chain_id = tbl[i].id;
            clear_counts();
            repeat (tbl[i].n) step();
            check($sformatf("row%0d_roc", i), int'(roc_id), tbl[i].roc);
            check($sformatf("row%0d_vld", i), int'(vld), tbl[i].vld);
            check($sformatf("row%0d_chg", i), chg_cnt, tbl[i].chg);
            check($sformatf("row%0d_fd", i),  fd_cnt, tbl[i].fd);
            check($sformatf("row%0d_ld", i),  ld_cnt, tbl[i].ld);
        end

        // Edge 169 reached; frame 8 shifts on cycles 187..190. Drop SCAN_EN mid-shift.
        repeat (19) step();
        scan_en = 1'b0;
        clear_counts();
        repeat (40) step();
        check("stop_fd",   fd_cnt, 1);
        check("stop_ld",   ld_cnt, 0);
        check("stop_ld_n", int'(ld_n), 1);
        check("stop_roc",  int'(roc_id), 6);
        check("stop_vld",  int'(vld), 1);

        scan_now = 1'b1;
        step();
        scan_now = 1'b0;
        check("now_ignored_ld_n", int'(ld_n), 1);
        scan_en = 1'b1; scan_now = 1'b1;
        step();
        scan_now = 1'b0;
        check("now_load_ld_n", int'(ld_n), 0);
        repeat (10) step();
        check("gap_idle_ld_n", int'(ld_n), 1);
        scan_now = 1'b1;
        step();
        scan_now = 1'b0;
        check("now_midgap_ld_n", int'(ld_n), 0);
        step();
        check("load2_ld_n", int'(ld_n), 0);
        step();
        check("shift_ld_n", int'(ld_n), 1);

        pgd = 1'b0;
        step();
        check_reset("midrst");
        pgd = 1'b1;
        clear_counts();
        repeat (30) step();
        check("rst2_pre_vld", int'(vld), 0);
        step();
        check("rst2_vld", int'(vld), 1);
        check("rst2_roc", int'(roc_id), 6);
        check("rst2_chg", chg_cnt, 1);

        check("w8_reset_roc", int'(roc_id8), 0);
        check("w8_reset_ld_n", int'(ld_n8), 0);
        pgd8 = 1'b1;
        clear_counts();
        repeat (11) step();
        check("w8_pre_vld", int'(vld8), 0);
        check("w8_fd", fd8_cnt, 1);
        step();
        check("w8_roc", int'(roc_id8), 8'hA5);
        check("w8_vld", int'(vld8), 1);
        check("w8_chg", chg8_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
